// File: rtl/altr_hps_mux41_rrarb.sv
// Round-robin arbiter and select sequencer for a shared 4:1 mux.
// Issues a registered one-hot grant plus the matching binary selector.
// Every ownership change passes through a one-cycle dead gap, so the mux
// output never switches source while a grant is live.
module altr_hps_mux41_rrarb #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    output logic [3:0] gnt,
    output logic [1:0] mux_sel,
    output logic       sel_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter saturation point and the count at which a contested owner is evicted.
    localparam logic [CNT_W-1:0] HOLD_SAT   = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0);
    localparam bit               TIMEOUT_EN = (HOLD_MAX != 0);

    state_t           state_reg, state_next;
    logic [3:0]       gnt_reg, gnt_next;
    logic [1:0]       mux_sel_reg, mux_sel_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic [3:0]       req_rot;
    logic             win_found;
    logic [1:0]       win_idx;
    logic             owner_exit;
    logic             contested;

    // Requests rotated so that bit 0 is the requester pointed at by ptr.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    // Pick the first set request at or after ptr (wrapping 3 -> 0).
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_idx   = ptr_reg + 2'(i);
            end
        end
    end

    // The owner leaves on its own release, on dropping its request, or when
    // its hold budget runs out while another requester is waiting.
    always_comb begin
        contested  = |(req & ~gnt_reg);
        owner_exit = rel[mux_sel_reg] | ~req[mux_sel_reg] |
                     (TIMEOUT_EN && (hold_cnt_reg == HOLD_LAST) && contested);
    end

    // Next-state and next-output logic; arbitration only happens in IDLE and GAP.
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        mux_sel_next  = mux_sel_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_IDLE, ST_GAP: begin
                gnt_next = 4'b0000;
                if (win_found) begin
                    state_next    = ST_GNT;
                    gnt_next      = 4'b0001 << win_idx;
                    mux_sel_next  = win_idx;
                    hold_cnt_next = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GNT: begin
                if (owner_exit) begin
                    state_next    = ST_GAP;
                    gnt_next      = 4'b0000;
                    ptr_next      = mux_sel_reg + 2'd1;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg < HOLD_SAT) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = 4'b0000;
            end
        endcase
    end

    // State and registered outputs; reset clears the grant with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= 4'b0000;
            mux_sel_reg  <= 2'd0;
            ptr_reg      <= 2'd0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            mux_sel_reg  <= mux_sel_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign mux_sel   = mux_sel_reg;
    assign sel_valid = |gnt_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
